// File: rtl/node_turn_if.sv
// Handshake and status bundle between a path planner/bench and the node turn
// sequencer. The master side drives the memory load port, the start request
// and the line follower's node reports. The slave side returns the turn code
// and path status.
interface node_turn_if #(
  parameter int IDX_W = 4
) ();
  logic             load_we;
  logic [IDX_W-1:0] load_addr;
  logic [1:0]       load_turn;
  logic [IDX_W:0]   path_len;
  logic             start;
  logic             node_flag;
  logic             node_changed;
  logic [1:0]       turn_flag;
  logic             end_path;
  logic             busy;
  logic [IDX_W-1:0] node_idx;
  logic             path_done;
  logic             fault;

  modport master (
    output load_we, load_addr, load_turn, path_len, start, node_flag, node_changed,
    input  turn_flag, end_path, busy, node_idx, path_done, fault
  );

  modport slave (
    input  load_we, load_addr, load_turn, path_len, start, node_flag, node_changed,
    output turn_flag, end_path, busy, node_idx, path_done, fault
  );
endinterface

// File: rtl/node_turn_sequencer.sv
// Node turn sequencer: steps through a planned list of 2-bit turn codes
// (0 straight, 1 right, 2 U-turn, 3 left), one per node, and raises end_path
// when the path completes or the robot sits on a node for too long.
//
// state | meaning
// IDLE  | out of reset, waiting for start; turn memory may be loaded
// RUN   | executing the path, node_idx selects the presented turn code
// DONE  | path completed, end_path held; memory may be reloaded
// FAULT | stuck-at-node timeout or illegal path_len; end_path and fault held
module node_turn_sequencer #(
  parameter int MAX_NODES = 16,
  parameter int IDX_W     = 4,
  parameter int TIMEOUT   = 3125000,
  parameter int TO_W      = 22
) (
  input logic        clk_3125KHz,
  input logic        rst_n,
  node_turn_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [IDX_W:0]  LEN_MAX = (IDX_W+1)'(MAX_NODES);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);

  logic [1:0] mem [MAX_NODES];

  state_t           state_q, state_d;
  logic [1:0]       turn_q, turn_d;
  logic             end_q, end_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;

  logic             start_ok;
  logic             last_node;
  logic [IDX_W-1:0] next_idx;

  assign start_ok  = bus.start && (bus.path_len != '0) && (bus.path_len <= LEN_MAX);
  assign last_node = ({1'b0, idx_q} == (len_q - 1'b1));
  assign next_idx  = idx_q + 1'b1;

  // Turn memory: loadable only while no path is executing, never reset.
  always_ff @(posedge clk_3125KHz) begin
    if (bus.load_we && (state_q == IDLE || state_q == DONE))
      mem[bus.load_addr] <= bus.load_turn;
  end

  // State and registered outputs.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      turn_q  <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; memory reads here see pre-write contents.
  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    end_d   = end_q;
    busy_d  = busy_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    fault_d = fault_q;
    len_d   = len_q;
    cnt_d   = '0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.path_len == '0) begin
            state_d = DONE;
            turn_d  = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
            end_d   = 1'b1;
            done_d  = 1'b1;
          end else if (!start_ok) begin
            state_d = FAULT;
            turn_d  = '0;
            busy_d  = 1'b0;
            end_d   = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d = RUN;
            idx_d   = '0;
            turn_d  = mem[0];
            busy_d  = 1'b1;
            end_d   = 1'b0;
            fault_d = 1'b0;
            len_d   = bus.path_len;
          end
        end
      end

      RUN: begin
        // A departure means node_flag has already fallen, so it beats a
        // timeout landing on the same edge.
        if (bus.node_changed) begin
          if (last_node) begin
            state_d = DONE;
            turn_d  = '0;
            busy_d  = 1'b0;
            end_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            idx_d  = next_idx;
            turn_d = mem[next_idx];
          end
        end else if (cnt_q == TO_MAX) begin
          state_d = FAULT;
          turn_d  = '0;
          busy_d  = 1'b0;
          end_d   = 1'b1;
          fault_d = 1'b1;
        end else if (bus.node_flag) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FAULT: begin
        if (start_ok) begin
          state_d = RUN;
          idx_d   = '0;
          turn_d  = mem[0];
          busy_d  = 1'b1;
          end_d   = 1'b0;
          fault_d = 1'b0;
          len_d   = bus.path_len;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.turn_flag = turn_q;
  assign bus.end_path  = end_q;
  assign bus.busy      = busy_q;
  assign bus.node_idx  = idx_q;
  assign bus.path_done = done_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_node_turn_sequencer.sv
// Directed bench for node_turn_sequencer with a shortened timeout.
module tb_node_turn_sequencer;

  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 40;

  logic clk_3125KHz = 1'b0;
  logic rst_n       = 1'b0;
  int   n_checks    = 0;
  int   n_fail      = 0;

  node_turn_if #(.IDX_W(IDX_W)) bus ();

  node_turn_sequencer #(
    .MAX_NODES(16),
    .IDX_W    (IDX_W),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (6)
  ) dut (
    .clk_3125KHz(clk_3125KHz),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  always #160 clk_3125KHz = ~clk_3125KHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land just after it, where inputs are driven and outputs sampled.
  task automatic tick();
    @(posedge clk_3125KHz);
    #1;
  endtask

  task automatic do_start(input int len);
    bus.path_len = (IDX_W+1)'(len);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Dwell on a node (turn code must hold), then leave it.
  task automatic visit(input logic [1:0] held);
    bus.node_flag = 1'b1;
    repeat (3) tick();
    chk("turn_held_on_node", bus.turn_flag, held);
    bus.node_flag    = 1'b0;
    bus.node_changed = 1'b1;
    tick();
    bus.node_changed = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [1:0] t, input logic e, input logic b,
                      input logic [3:0] i, input logic d, input logic f);
    chk({tag, ".turn"},  bus.turn_flag, t);
    chk({tag, ".end"},   bus.end_path,  e);
    chk({tag, ".busy"},  bus.busy,      b);
    chk({tag, ".idx"},   bus.node_idx,  i);
    chk({tag, ".done"},  bus.path_done, d);
    chk({tag, ".fault"}, bus.fault,     f);
  endtask

  initial begin
    logic [1:0] plan [4] = '{2'd1, 2'd0, 2'd3, 2'd2};

    bus.load_we = 0; bus.load_addr = '0; bus.load_turn = '0; bus.path_len = '0;
    bus.start = 0; bus.node_flag = 0; bus.node_changed = 0;
    #5;
    outs("reset", 2'd0, 0, 0, 4'd0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      bus.load_we = 1; bus.load_addr = 4'(i); bus.load_turn = plan[i];
      tick();
    end
    bus.load_we = 0;

    // Nominal path; path_len changes mid-path must not matter.
    do_start(4);
    outs("start", 2'd1, 0, 1, 4'd0, 0, 0);
    bus.path_len = 5'd2;
    visit(2'd1); outs("node1", 2'd0, 0, 1, 4'd1, 0, 0);
    visit(2'd0); outs("node2", 2'd3, 0, 1, 4'd2, 0, 0);
    visit(2'd3); outs("node3", 2'd2, 0, 1, 4'd3, 0, 0);
    visit(2'd2); outs("last", 2'd0, 1, 0, 4'd3, 1, 0);
    tick();      outs("done_hold", 2'd0, 1, 0, 4'd3, 0, 0);

    // node_changed in DONE is ignored.
    bus.node_changed = 1; tick(); bus.node_changed = 0;
    outs("nc_in_done", 2'd0, 1, 0, 4'd3, 0, 0);

    // Timeout: TIMEOUT edges with node_flag high is still fine, the next one faults.
    do_start(4);
    outs("restart_done", 2'd1, 0, 1, 4'd0, 0, 0);
    bus.node_flag = 1;
    repeat (TIMEOUT) tick();
    outs("to_edge", 2'd1, 0, 1, 4'd0, 0, 0);
    tick();
    outs("to_fault", 2'd0, 1, 0, 4'd0, 0, 1);
    bus.node_flag = 0;

    do_start(0);
    outs("fault_len0", 2'd0, 1, 0, 4'd0, 0, 1);
    do_start(4);
    outs("fault_exit", 2'd1, 0, 1, 4'd0, 0, 0);

    // Dropping node_flag just short of the limit clears the counter.
    bus.node_flag = 1; repeat (TIMEOUT-1) tick();
    bus.node_flag = 0; tick();
    bus.node_flag = 1; repeat (TIMEOUT-1) tick();
    bus.node_flag = 0; repeat (3) tick();
    outs("to_cleared", 2'd1, 0, 1, 4'd0, 0, 0);

    // Departure on the same edge the timeout would fire: departure wins.
    bus.node_flag = 1; repeat (TIMEOUT) tick();
    bus.node_flag = 0; bus.node_changed = 1; tick(); bus.node_changed = 0;
    outs("nc_beats_to", 2'd0, 0, 1, 4'd1, 0, 0);
    repeat (TIMEOUT + 5) tick();
    chk("no_fault_after_nc", bus.fault, 1'b0);

    // Writes and starts while busy are ignored.
    bus.load_we = 1; bus.load_addr = 4'd2; bus.load_turn = 2'd1; tick(); bus.load_we = 0;
    do_start(16);
    outs("start_in_run", 2'd0, 0, 1, 4'd1, 0, 0);
    visit(2'd0);
    outs("mem_protected", 2'd3, 0, 1, 4'd2, 0, 0);

    // Asynchronous reset mid-path, away from any clock edge.
    #50 rst_n = 0;
    #1 outs("async_rst", 2'd0, 0, 0, 4'd0, 0, 0);
    tick(); rst_n = 1; tick();

    bus.node_changed = 1; tick(); bus.node_changed = 0;
    outs("nc_in_idle", 2'd0, 0, 0, 4'd0, 0, 0);

    do_start(0);
    outs("len0", 2'd0, 1, 0, 4'd0, 1, 0);
    tick();
    chk("len0_pulse_end", bus.path_done, 1'b0);
    do_start(17);
    outs("len17", 2'd0, 1, 0, 4'd0, 0, 1);

    // Memory survives reset.
    do_start(4);
    outs("post_rst", 2'd1, 0, 1, 4'd0, 0, 0);
    visit(2'd1); visit(2'd0);
    outs("post_rst_idx2", 2'd3, 0, 1, 4'd2, 0, 0);
    visit(2'd3); visit(2'd2);
    outs("post_rst_done", 2'd0, 1, 0, 4'd3, 1, 0);

    // Write and start together: start sees the old mem[0], the write lands.
    bus.load_we = 1; bus.load_addr = 4'd0; bus.load_turn = 2'd2;
    do_start(1);
    bus.load_we = 0;
    outs("wr_start", 2'd1, 0, 1, 4'd0, 0, 0);
    visit(2'd1);
    outs("len1_done", 2'd0, 1, 0, 4'd0, 1, 0);
    do_start(1);
    chk("new_mem0", bus.turn_flag, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
